// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam logic [7:0] LineFeed = 8'h0A;

  // Index width that stays at least one bit wide even for a single requester.
  function automatic int unsigned OwnerIdxW(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after last_i+1 that is requesting.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = OwnerIdxW(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic            found;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // Scan NumReq candidates starting just past the previous owner, wrapping once.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      sum  = {1'b0, last_i} + (IdxW+1)'(i);
      sum  = (sum >= (IdxW+1)'(NumReq)) ? (sum - (IdxW+1)'(NumReq)) : sum;
      cand = sum[IdxW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; a grant is held for a whole line or burst.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxBurst    = 16,
  parameter bit          LineLock    = 1'b1,
  parameter int unsigned IdleTimeout = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                tx_valid_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_ready_i,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o
);

  localparam int unsigned IdxW   = OwnerIdxW(NumReq);
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);
  localparam int unsigned IdleW  = $clog2(IdleTimeout + 1);

  localparam logic [IdxW-1:0]   LastInit = IdxW'(NumReq - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);
  localparam logic [IdleW-1:0]  IdleMax  = IdleW'(IdleTimeout);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_owner_q, last_owner_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              own_valid;
  logic              own_last;
  logic [7:0]        own_data;
  logic              out_free;
  logic              accept;
  logic              end_byte;

  uart_tx_arbiter_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i  (req_valid_i),
    .last_i (last_owner_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign own_valid = req_valid_i[owner_q];
  assign own_last  = req_last_i[owner_q];
  assign own_data  = req_data_i[{owner_q, 3'b000} +: 8];
  assign out_free  = ~tx_valid_q | tx_ready_i;
  assign accept    = (state_q == OWN) & own_valid & out_free;

  // Next-state: output register, arbitration, burst/idle counters and release.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    idle_d       = idle_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    end_byte     = 1'b0;

    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = own_data;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d = OWN;
          grant_d = pick_gnt;
          owner_d = pick_idx;
          burst_d = '0;
          idle_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (accept && (burst_q != BurstMax)) begin
          burst_d = burst_q + 1'b1;
        end else begin
          burst_d = burst_q;
        end
        if (own_valid) begin
          idle_d = '0;
        end else if (idle_q != IdleMax) begin
          idle_d = idle_q + 1'b1;
        end else begin
          idle_d = idle_q;
        end
        end_byte = own_last | (LineLock & (own_data == LineFeed)) | (burst_d == BurstMax);
        // The byte in flight is never dropped on release; it drains on its own.
        if ((accept && end_byte) || (idle_d == IdleMax)) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end else begin
          state_d = OWN;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset discards any pending output byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LastInit;
      burst_q      <= '0;
      idle_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      idle_q       <= idle_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign req_ready_o = grant_q & {NumReq{out_free}};
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == OWN) | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester streams, monitor checks UART bytes.
module tb_uart_tx_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       take0, take1;

  uart_tx_arbiter #(
    .NumReq      (2),
    .MaxBurst    (4),
    .LineLock    (1'b1),
    .IdleTimeout (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    int n = 0;
    while (grant_o !== g && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, {30'd0, grant_o}, {30'd0, g});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Requester models: present queue heads, pop on a completed handshake.
  initial begin
    req_valid_i = 2'b00;
    req_data_i  = 16'h0000;
    req_last_i  = 2'b00;
    forever begin
      @(negedge clk_i);
      take0 = req_valid_i[0] & req_ready_o[0];
      take1 = req_valid_i[1] & req_ready_o[1];
      @(posedge clk_i);
      #1;
      if (take0 && q0.size() > 0) void'(q0.pop_front());
      if (take1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        req_valid_i[0]   = 1'b1;
        req_data_i[7:0]  = q0[0][7:0];
        req_last_i[0]    = q0[0][8];
      end else begin
        req_valid_i[0]   = 1'b0;
        req_data_i[7:0]  = 8'h00;
        req_last_i[0]    = 1'b0;
      end
      if (q1.size() > 0) begin
        req_valid_i[1]   = 1'b1;
        req_data_i[15:8] = q1[0][7:0];
        req_last_i[1]    = q1[0][8];
      end else begin
        req_valid_i[1]   = 1'b0;
        req_data_i[15:8] = 8'h00;
        req_last_i[1]    = 1'b0;
      end
    end
  end

  // Monitor: every byte the UART takes must be the next expected one.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data_o);
        end else begin
          chk("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n0, t0, t1, n;
    rst_i      = 1'b1;
    tx_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready_o}, 32'd0);
    rst_i = 1'b0;

    // Line lock: both stream "AB\n"; req0 wins first after reset, one idle grant cycle between.
    @(posedge clk_i); #2;
    q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h00A);
    q1.push_back(9'h041); q1.push_back(9'h042); q1.push_back(9'h00A);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h0A);
    @(negedge clk_i);
    wait_grant(2'b01, "ll_first_owner");
    n1 = 0;
    while (grant_o == 2'b01 && n1 < 20) begin n1++; @(negedge clk_i); end
    n0 = 0;
    while (grant_o == 2'b00 && n0 < 20) begin n0++; @(negedge clk_i); end
    chk("ll_owner0_cycles", n1, 3);
    chk("ll_bubble_cycles", n0, 1);
    chk("ll_second_owner", {30'd0, grant_o}, 32'd2);
    wait_idle("ll_idle");

    // Basic release on last.
    @(posedge clk_i); #2;
    q0.push_back(9'h041); q0.push_back(9'h142);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    @(negedge clk_i);
    wait_grant(2'b01, "basic_grant");
    chk("basic_first_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("basic_ready", {30'd0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    chk("basic_data0", {24'd0, tx_data_o}, 32'h41);
    chk("basic_grant_held", {30'd0, grant_o}, 32'd1);
    @(negedge clk_i);
    chk("basic_data1", {24'd0, tx_data_o}, 32'h42);
    chk("basic_grant_drop", {30'd0, grant_o}, 32'd0);
    chk("basic_busy_drain", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    chk("basic_busy_low", {31'd0, busy_o}, 32'd0);

    // Burst cap of 4: req1 streams 0x00..0x09, req0 cuts in after the first burst.
    @(posedge clk_i); #2;
    for (int i = 0; i < 10; i++) q1.push_back({(i == 9) ? 1'b1 : 1'b0, 8'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hA0);
    for (int i = 4; i < 10; i++) exp_q.push_back(8'(i));
    @(negedge clk_i);
    wait_grant(2'b10, "burst_grant1");
    q0.push_back(9'h1A0);
    wait_grant(2'b01, "burst_grant0");
    wait_grant(2'b10, "burst_regrant1");
    wait_idle("burst_idle");

    // Backpressure: 0x55 held for 5 cycles, next byte accepted as ready rises.
    @(posedge clk_i); #1;
    tx_ready_i = 1'b0;
    #1;
    q0.push_back(9'h055); q0.push_back(9'h156);
    exp_q.push_back(8'h55); exp_q.push_back(8'h56);
    n = 0;
    @(negedge clk_i);
    while (tx_valid_o !== 1'b1 && n < 50) begin n++; @(negedge clk_i); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_hold_data", {24'd0, tx_data_o}, 32'h55);
      chk("bp_ready_low", {30'd0, req_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_ready_rise", {30'd0, req_ready_o}, 32'd1);
    chk("bp_data_still", {24'd0, tx_data_o}, 32'h55);
    wait_idle("bp_idle");

    // Idle timeout of 8: grant moves 9 cycles after the owner's valid drops.
    @(posedge clk_i); #2;
    q0.push_back(9'h061);
    exp_q.push_back(8'h61); exp_q.push_back(8'h71);
    @(negedge clk_i);
    wait_grant(2'b01, "idle_grant0");
    n = 0;
    while (req_valid_i[0] && n < 20) begin n++; @(negedge clk_i); end
    t0 = cyc;
    q1.push_back(9'h171);
    wait_grant(2'b10, "idle_grant1");
    t1 = cyc;
    chk("idle_timeout_cycles", t1 - t0, 9);
    wait_idle("idle_idle");

    // Reset mid-stream with req1 granted and a byte pending.
    @(posedge clk_i); #1;
    tx_ready_i = 1'b0;
    #1;
    q1.push_back(9'h081); q1.push_back(9'h182);
    n = 0;
    @(negedge clk_i);
    while (!(grant_o == 2'b10 && tx_valid_o) && n < 50) begin n++; @(negedge clk_i); end
    chk("rm_pre_grant", {30'd0, grant_o}, 32'd2);
    #1 rst_i = 1'b1;
    #1;
    chk("rm_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("rm_tx_data", {24'd0, tx_data_o}, 32'd0);
    chk("rm_grant", {30'd0, grant_o}, 32'd0);
    chk("rm_busy", {31'd0, busy_o}, 32'd0);
    chk("rm_req_ready", {30'd0, req_ready_o}, 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk_i);
    rst_i      = 1'b0;
    tx_ready_i = 1'b1;
    @(posedge clk_i); #2;
    q0.push_back(9'h191);
    q1.push_back(9'h192);
    exp_q.push_back(8'h91); exp_q.push_back(8'h92);
    @(negedge clk_i);
    n = 0;
    while (grant_o == 2'b00 && n < 50) begin n++; @(negedge clk_i); end
    chk("rm_first_after_reset", {30'd0, grant_o}, 32'd1);
    wait_idle("rm_idle");

    repeat (5) @(negedge clk_i);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
